// File: rtl/param_switch_core.sv
// Parametrised N-port store-and-forward switch: address-table routing, priority/round-robin
// arbitration per output, and one {addr,data} FIFO per output. Option: SWITCH_DROP_CNT_EN.
module param_switch_core #(
   parameter int  NUM_PORTS  = 4,
   parameter int  DATA_W     = 16,
   parameter int  ADDR_W     = 16,
   parameter int  PRIO_W     = 2,
   parameter int  FIFO_DEPTH = 8,
   parameter int  AE_TH      = 2,
   parameter int  AF_TH      = 6,
   localparam int SEL_W      = $clog2(NUM_PORTS)
) (
`ifdef SWITCH_DROP_CNT_EN
   output logic [15:0]                  drop_cnt,
`endif
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_PORTS*DATA_W-1:0]  data_in,
   input  logic [NUM_PORTS*ADDR_W-1:0]  addr_in,
   input  logic [NUM_PORTS-1:0]         wr_en,
   output logic [NUM_PORTS-1:0]         data_rcv,
   output logic [NUM_PORTS-1:0]         fifo_empty,
   output logic [NUM_PORTS-1:0]         fifo_full,
   output logic [NUM_PORTS-1:0]         fifo_ae,
   output logic [NUM_PORTS-1:0]         fifo_af,
   output logic [NUM_PORTS*DATA_W-1:0]  data_out,
   output logic [NUM_PORTS*ADDR_W-1:0]  addr_out,
   input  logic [NUM_PORTS-1:0]         rd_en,
   output logic [NUM_PORTS-1:0]         data_rdy,
   input  logic [NUM_PORTS*PRIO_W-1:0]  prio_val,
   input  logic                         prio_wr,
   input  logic                         port_en,
   input  logic                         port_wr,
   input  logic [SEL_W-1:0]             port_sel,
   input  logic [ADDR_W-1:0]            port_addr
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + DATA_W;

   logic [NUM_PORTS-1:0][ADDR_W-1:0] r_table;
   logic [NUM_PORTS*PRIO_W-1:0]      r_prio;
   logic [NUM_PORTS-1:0][SEL_W-1:0]  r_rr;
   logic [ENT_W-1:0]                 r_mem [NUM_PORTS][FIFO_DEPTH];
   logic [NUM_PORTS-1:0][PTR_W-1:0]  r_wp, r_rp;
   logic [NUM_PORTS-1:0][CNT_W-1:0]  r_cnt;

   logic [NUM_PORTS-1:0]             w_match, w_gnt, w_push, w_pop, w_empty, w_full;
   logic [NUM_PORTS-1:0][SEL_W-1:0]  w_dst, w_win;

   // Lowest matching table index wins, so scan downwards and let later hits overwrite.
   always_comb begin
      w_match = '0;
      w_dst   = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         for (int j = NUM_PORTS-1; j >= 0; j--)
            if (r_table[j] == addr_in[i*ADDR_W +: ADDR_W]) begin
               w_match[i] = 1'b1;
               w_dst[i]   = SEL_W'(j);
            end
   end

   // Scan from rr_ptr; strict '>' keeps the earliest requester among equal top priorities.
   always_comb begin
      logic [PRIO_W-1:0] v_best;
      int                idx;
      w_gnt  = '0;
      w_win  = '0;
      v_best = '0;
      idx    = 0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         v_best = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(r_rr[j]) + k) % NUM_PORTS;
            if (wr_en[idx] && port_en && w_match[idx] && w_dst[idx] == SEL_W'(j) &&
                (!w_gnt[j] || r_prio[idx*PRIO_W +: PRIO_W] > v_best)) begin
               w_gnt[j] = 1'b1;
               w_win[j] = SEL_W'(idx);
               v_best   = r_prio[idx*PRIO_W +: PRIO_W];
            end
         end
      end
   end

   always_comb begin
      data_rcv = '0;
      data_out = '0;
      addr_out = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         w_empty[j]  = (r_cnt[j] == '0);
         w_full[j]   = (r_cnt[j] == CNT_W'(FIFO_DEPTH));
         fifo_ae[j]  = (r_cnt[j] <= CNT_W'(AE_TH));
         fifo_af[j]  = (r_cnt[j] >= CNT_W'(AF_TH));
         w_push[j]   = w_gnt[j] & ~w_full[j];
         w_pop[j]    = rd_en[j] & ~w_empty[j];
         data_out[j*DATA_W +: DATA_W] = r_mem[j][r_rp[j]][DATA_W-1:0];
         addr_out[j*ADDR_W +: ADDR_W] = r_mem[j][r_rp[j]][ENT_W-1:DATA_W];
      end
      for (int i = 0; i < NUM_PORTS; i++)
         data_rcv[i] = wr_en[i] & port_en &
                       (~w_match[i] | (w_push[w_dst[i]] & (w_win[w_dst[i]] == SEL_W'(i))));
   end

   assign fifo_empty = w_empty;
   assign fifo_full  = w_full;
   assign data_rdy   = ~w_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PORTS; i++) r_table[i] <= ADDR_W'(i);
         r_prio <= '0;
      end else begin
         if (port_wr && !port_en) r_table[port_sel] <= port_addr;
         if (prio_wr)             r_prio <= prio_val;
      end
   end

   // The round-robin pointer only moves when the winning beat is actually accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rr <= '0;
      end else begin
         for (int j = 0; j < NUM_PORTS; j++)
            if (w_push[j])
               r_rr[j] <= (w_win[j] == SEL_W'(NUM_PORTS-1)) ? '0 : w_win[j] + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < NUM_PORTS; j++)
            for (int d = 0; d < FIFO_DEPTH; d++) r_mem[j][d] <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (w_push[j]) begin
               r_mem[j][r_wp[j]] <= {addr_in[w_win[j]*ADDR_W +: ADDR_W],
                                     data_in[w_win[j]*DATA_W +: DATA_W]};
               r_wp[j] <= r_wp[j] + PTR_W'(1);
            end
            if (w_pop[j]) r_rp[j] <= r_rp[j] + PTR_W'(1);
            r_cnt[j] <= r_cnt[j] + CNT_W'(w_push[j]) - CNT_W'(w_pop[j]);
         end
      end
   end

`ifdef SWITCH_DROP_CNT_EN
   localparam int DN_W = SEL_W + 1;
   logic [15:0]     r_drop;
   logic [DN_W-1:0] w_drop_n;
   logic [16:0]     w_drop_sum;

   always_comb begin
      w_drop_n = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (wr_en[i] && port_en && !w_match[i]) w_drop_n = w_drop_n + DN_W'(1);
      w_drop_sum = {1'b0, r_drop} + 17'(w_drop_n);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_drop <= '0;
      else        r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
   end

   assign drop_cnt = r_drop;
`endif

endmodule
